// File: rtl/conv_pkg.sv
// conv_pkg -- shared constants for the streaming 3x3 convolution engine.
//   N_COEF          : number of kernel taps (3x3)
//   K_*             : tap indices in raster order (0 = top-left, 8 = bottom-right)
//   KERNEL_DEFAULT  : power-up kernel 8,16,8 / 16,32,16 / 8,16,8 (sum 128)
//   acc_width()     : accumulator width that cannot overflow for 9 taps
package conv_pkg;

  localparam int N_COEF = 9;

  localparam int K_TL = 0;
  localparam int K_TC = 1;
  localparam int K_TR = 2;
  localparam int K_ML = 3;
  localparam int K_CENTER = 4;
  localparam int K_MR = 5;
  localparam int K_BL = 6;
  localparam int K_BC = 7;
  localparam int K_BR = 8;

  localparam int KERNEL_DEFAULT [N_COEF] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

  // Product is DATA_W+COEF_W+1 bits signed; nine of them need 4 more bits.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if -- pixel-in / result-out stream bundle.
//   in_valid/in_ready/din           : pixel stream into the engine
//   out_valid/out_ready/dout/out_last: result stream out of the engine
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. A producer holding valid keeps its data stable until the transfer;
// ready may depend combinationally on the consumer side, valid never on ready.
// Modports: master = pixel source / result consumer, slave = the engine.
interface conv2d_stream_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  dout;
  logic              out_last;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, out_last
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, out_last
  );
endinterface

// File: rtl/line_buffer.sv
// line_buffer -- one image row of pixel storage.
//   clk     : clock
//   en_i    : write enable (one write per enabled cycle)
//   addr_i  : column address, shared by read and write
//   wdata_i : data written at addr_i
//   rdata_o : combinational read of addr_i; returns the old contents in the
//             cycle the same address is written (read-before-write)
// No reset: every location is rewritten before it is read within a frame.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream -- streaming valid-mode 3x3 convolution with programmable
// signed kernel, arithmetic shift and unsigned saturation.
//   clk, rst_n  : clock, asynchronous active-low reset
//   s           : stream bundle (slave side): pixels in, results out
//   coef_we     : kernel write strobe, honoured only while busy is low
//   coef_addr   : tap index 0..8 raster order; 9..15 ignored
//   coef_data   : signed tap value
//   busy        : frame in progress or results still in the pipeline
// Pipeline: accept edge loads the window, next edge registers the nine
// products, next edge registers the clamped sum as dout. One global enable
// freezes window, line buffers and all stages while a result is stalled.
module conv2d_stream #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  conv2d_stream_if.slave           s,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     busy
);
  import conv_pkg::*;

  localparam int ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int EXT_W  = ACC_W + OUT_W + 1;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({OUT_W{1'b1}});

  logic en, accept;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] win_q [3][3];
  logic s1_v_q, s1_last_q, s2_v_q, s2_last_q;
  logic signed [PROD_W-1:0] prod_q [N_COEF];
  logic signed [PROD_W-1:0] prod_d [N_COEF];
  logic signed [COEF_W-1:0] coef_q [N_COEF];
  logic signed [ACC_W-1:0] sum, shifted;
  logic signed [EXT_W-1:0] ext;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic out_valid_q, out_last_q;
  logic win_issue, win_last;

  // Everything advances unless a presented result is being held back.
  assign en       = !(out_valid_q && !s.out_ready);
  assign accept   = s.in_valid && en;
  assign s.in_ready = en;

  assign win_issue = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign win_last  = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

  // Raster position of the next pixel; wraps to 0,0 after a full frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // lb0 holds the row above, lb1 the row two above; lb1 takes what lb0 drops.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk(clk), .en_i(accept), .addr_i(col_q), .wdata_i(s.din), .rdata_o(lb0_rd)
  );
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk(clk), .en_i(accept), .addr_i(col_q), .wdata_i(lb0_rd), .rdata_o(lb1_rd)
  );

  // Window row 0 is the top row, column 2 the newest column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_rd;
      win_q[1][2] <= lb0_rd;
      win_q[2][2] <= s.din;
    end
  end

  always_comb begin
    for (int k = 0; k < N_COEF; k++)
      prod_d[k] = PROD_W'($signed({1'b0, win_q[k / 3][k % 3]})) * PROD_W'(coef_q[k]);
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_COEF; k++) sum = sum + ACC_W'(prod_q[k]);
    shifted = sum >>> SHIFT;
    ext     = EXT_W'(shifted);
    if (ext[EXT_W-1])       dout_d = '0;
    else if (ext > SAT_MAX) dout_d = '1;
    else                    dout_d = ext[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      dout_q      <= '0;
      for (int k = 0; k < N_COEF; k++) prod_q[k] <= '0;
    end else if (en) begin
      s1_v_q      <= accept && win_issue;
      s1_last_q   <= accept && win_last;
      prod_q      <= prod_d;
      s2_v_q      <= s1_v_q;
      s2_last_q   <= s1_last_q;
      out_valid_q <= s2_v_q;
      out_last_q  <= s2_last_q;
      if (s2_v_q) dout_q <= dout_d;
    end
  end

  // Kernel is read at the product stage, so a write landing with the first
  // pixel of a frame still applies to that whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_COEF; k++) coef_q[k] <= COEF_W'(KERNEL_DEFAULT[k]);
    end else if (coef_we && !busy) begin
      for (int k = 0; k < N_COEF; k++)
        if (coef_addr == 4'(k)) coef_q[k] <= coef_data;
    end
  end

  // Counters off 0,0 means a frame is mid-way; any valid stage means results pending.
  assign busy = (row_q != '0) || (col_q != '0) || s1_v_q || s2_v_q || out_valid_q;

  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;
  assign s.dout      = dout_q;

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;
  import conv_pkg::*;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 0;
  localparam int N_PIX  = IMG_W * IMG_H;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coef_we;
  logic [3:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic busy;

  always #5 clk = ~clk;

  conv2d_stream_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  conv2d_stream #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W),
    .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(bus),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];
  bit exp_last_q[$];
  int pix [IMG_H][IMG_W];
  int model_k [N_COEF];
  bit rand_ready = 1'b0;
  bit rand_gap = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain 2D valid-mode convolution over the stored frame.
  task automatic expect_frame();
    longint s;
    longint maxv;
    maxv = (longint'(1) << OUT_W) - 1;
    for (int i = 2; i < IMG_H; i++) begin
      for (int j = 2; j < IMG_W; j++) begin
        s = 0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            s += longint'(pix[i-2+a][j-2+b]) * longint'(model_k[a*3+b]);
        s = s >>> SHIFT;
        if (s < 0) s = 0;
        else if (s > maxv) s = maxv;
        exp_q.push_back(OUT_W'(s));
        exp_last_q.push_back(i == IMG_H - 1 && j == IMG_W - 1);
      end
    end
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic prev_stall;
    logic [OUT_W-1:0] prev_dout;
    logic prev_last;
    logic [OUT_W-1:0] e;
    bit el;
    prev_stall = 1'b0;
    prev_dout = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_dout", bus.dout, prev_dout);
          check("stall_last", bus.out_last, prev_last);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %0d expected none", bus.dout);
          end else begin
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check("dout", bus.dout, e);
            check("out_last", bus.out_last, el);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_dout  = bus.dout;
        prev_last  = bus.out_last;
      end
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic send_pixel(input int p);
    int g;
    int budget;
    bit acc;
    g = rand_gap ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < g; i++) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.din = DATA_W'(p);
    budget = 0;
    acc = 1'b0;
    while (!acc && budget < 1000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no in_ready expected accept");
    end
  endtask

  // mode 0 = constant val, 1 = ramp r*IMG_W+c, 2 = random pixels.
  task automatic run_frame(input int mode, input int val, input int mid_at,
                           input int mid_data, input int n_pix);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = (mode == 0) ? val : (mode == 1) ? r * IMG_W + c
                                                    : int'($urandom_range(0, 255));
    if (n_pix == N_PIX) expect_frame();
    for (int idx = 0; idx < n_pix; idx++) begin
      if (idx == mid_at) begin
        coef_we = 1'b1;
        coef_addr = 4'(K_CENTER);
        coef_data = COEF_W'(mid_data);
      end
      send_pixel(pix[idx / IMG_W][idx % IMG_W]);
      if (idx == mid_at) coef_we = 1'b0;
      if (idx == 0) check("busy_rise", busy, 1);
    end
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we = 1'b1;
    coef_addr = 4'(addr);
    coef_data = COEF_W'(data);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    model_k[addr] = data;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    check("busy_idle", busy, 0);
    check("idle_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < N_COEF; k++) model_k[k] = KERNEL_DEFAULT[k];
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.din = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    for (int k = 0; k < N_COEF; k++) model_k[k] = KERNEL_DEFAULT[k];

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // Default kernel: constant 10, then ramp.
    run_frame(0, 10, -1, 0, N_PIX);
    wait_drain();
    run_frame(1, 0, -1, 0, N_PIX);
    wait_drain();

    // Ramp under random backpressure and input gaps.
    rand_ready = 1'b1;
    rand_gap = 1'b1;
    run_frame(1, 0, -1, 0, N_PIX);
    wait_drain();

    // Random kernel, two back-to-back random frames, still stalling.
    for (int k = 0; k < N_COEF; k++) write_coef(k, int'($urandom_range(0, 60)) - 20);
    rand_gap = 1'b0;
    run_frame(2, 0, -1, 0, N_PIX);
    run_frame(2, 0, -1, 0, N_PIX);
    wait_drain();
    rand_ready = 1'b0;

    // Saturation high and low.
    for (int k = 0; k < N_COEF; k++) write_coef(k, 127);
    run_frame(0, 255, -1, 0, N_PIX);
    wait_drain();
    for (int k = 0; k < N_COEF; k++) write_coef(k, -1);
    run_frame(0, 5, -1, 0, N_PIX);
    wait_drain();

    // Mid-frame coefficient write is dropped; idle write takes effect.
    do_reset();
    run_frame(0, 10, 20, 0, N_PIX);
    wait_drain();
    write_coef(K_CENTER, 0);
    run_frame(0, 10, -1, 0, N_PIX);
    wait_drain();

    // Abort after 20 pixels, then a clean default frame.
    do_reset();
    run_frame(0, 10, -1, 0, 20);
    do_reset();
    run_frame(0, 10, -1, 0, N_PIX);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
